// File: rtl/lcd_pixel_fifo.sv
// Rate adapter from the PPU pixel strobe to the ILI9341 driver: buffers 2-bit pixels,
// drains them at most one per DRAIN_CLKS cycles and only from a frame boundary onward.
module lcd_pixel_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int DRAIN_CLKS = 4,
    parameter int FRAME_PIX  = 23040
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tft_initialized,
    input  logic              in_vblank,
    input  logic              in_write,
    input  logic [1:0]        in_col,
    output logic              out_vblank,
    output logic              out_write,
    output logic [1:0]        out_col,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              frame_err
);

    localparam int TMR_W = (DRAIN_CLKS > 2) ? $clog2(DRAIN_CLKS) : 1;
    localparam int CNT_W = 15;

    typedef enum logic [1:0] {ST_FLUSH, ST_SYNC, ST_RUN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W:0]    wr_ptr, rd_ptr;
    logic [1:0]         mem [DEPTH];
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   pix_cnt;

    logic vblank_rise, clear_fifo, run_active, sync_start;
    logic empty, full, push_req, push, pop, drop;
    logic [1:0] head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign vblank_rise = in_vblank & ~out_vblank;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_FLUSH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!tft_initialized) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_FLUSH: state_nxt = ST_SYNC;
                ST_SYNC:  if (vblank_rise) state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_RUN;
                default:  state_nxt = ST_FLUSH;
            endcase
        end
    end

    // Dropping tft_initialized acts immediately so the FIFO is already empty the next cycle.
    always_comb begin
        clear_fifo = (state == ST_FLUSH) || !tft_initialized;
        run_active = (state == ST_RUN) && tft_initialized;
        sync_start = (state == ST_SYNC) && tft_initialized && vblank_rise;
    end

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (level == (ADDR_W+1)'(DEPTH));
    assign push_req = run_active & in_write;
    // An empty FIFO forwards the incoming pixel so it leaves one cycle after the strobe.
    assign pop      = run_active & (timer == '0) & (~empty | push_req);
    assign head     = empty ? in_col : mem[rd_ptr[ADDR_W-1:0]];
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset || clear_fifo) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= in_col;
    end

    always_ff @(posedge clk) begin
        if (reset)              timer <= '0;
        else if (pop)           timer <= TMR_W'(DRAIN_CLKS - 1);
        else if (timer != '0)   timer <= timer - 1'b1;
    end

    // A pixel strobed on the same cycle as vblank_rise belongs to the new frame.
    always_ff @(posedge clk) begin
        if (reset || clear_fifo) begin
            pix_cnt <= '0;
        end else if (sync_start) begin
            pix_cnt <= '0;
        end else if (run_active) begin
            if (vblank_rise)   pix_cnt <= in_write ? CNT_W'(1) : '0;
            else if (in_write) pix_cnt <= sat_inc(pix_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vblank <= 1'b0;
            out_write  <= 1'b0;
            out_col    <= 2'd0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            out_vblank <= in_vblank;
            out_write  <= pop;
            if (pop) out_col <= head;
            overflow   <= overflow | drop;
            frame_err  <= run_active & vblank_rise & (pix_cnt != CNT_W'(FRAME_PIX));
        end
    end

endmodule

// File: doc/lcd_pixel_fifo.md
Name: lcd_pixel_fifo

Overview:
- Rate adapter between the PPU pixel output and the ILI9341 TFT driver, all on the 16 MHz (4x PPU) clock.
- Buffers 2-bit GameBoy pixels from the PPU strobe into a small FIFO.
- Issues them to the TFT driver no faster than one per DRAIN_CLKS cycles, holding the colour stable while the driver sends both RGB565 bytes.
- Discards pixels until the driver is initialized and a frame boundary (vblank rise) is seen, so the first written pixel is the top-left of a frame. Flags overflow and per-frame pixel-count errors.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 4.
- ADDR_W, 4, log2(DEPTH).
- DRAIN_CLKS, 4, minimum cycles between out_write pulses; must match the driver's 4-cycle hi/lo byte sequence.
- FRAME_PIX, 23040, expected pixels per frame (160x144).

Ports:
- clk  in  1  system clock, 16 MHz
- reset  in  1  synchronous, active-high reset
- tft_initialized  in  1  driver ready; pixels are accepted only while high
- in_vblank  in  1  PPU vblank level
- in_write  in  1  PPU pixel strobe, one cycle per pixel
- in_col  in  2  PPU pixel colour, valid with in_write
- out_vblank  out  1  in_vblank registered one cycle
- out_write  out  1  one-cycle pixel strobe to driver (lcd_write)
- out_col  out  2  pixel colour to driver (lcd_col); held until next out_write
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky; push dropped because FIFO full
- frame_err  out  1  one-cycle pulse; frame pixel count != FRAME_PIX

Behaviour:
- Reset: all outputs 0, FIFO empty, drain timer 0, pixel count 0, state FLUSH.
- vblank_rise is in_vblank high while out_vblank (previous value) is low.
- State FLUSH:
  - Entered from reset, or from any state on the first cycle tft_initialized is low.
  - FIFO pointers and pixel count clear; pushes ignored; no out_write.
  - overflow keeps its value.
  - Goes to SYNC when tft_initialized is high.
- State SYNC:
  - Pushes ignored.
  - Goes to RUN on vblank_rise; the pixel count clears that cycle.
- State RUN:
  - Push: in_write while in RUN writes in_col at the write pointer.
  - Every in_write increments the pixel count (15 bits, saturates at 32767), whether or not the push is accepted.
  - Push with FIFO full: dropped unless a pop happens in the same cycle, in which case it is accepted. A drop sets overflow; only reset clears it.
  - Pop: occurs when the FIFO is not empty and the drain timer is 0. It registers out_write=1 and out_col=head the next cycle, advances the read pointer, and loads the timer with DRAIN_CLKS-1.
  - The timer decrements to 0 on non-pop cycles. out_write is high for exactly one cycle per pop.
  - Push and pop in the same cycle: level unchanged.
  - Latency: push at cycle N into an empty FIFO with timer 0 gives out_write at N+1 with that colour. The push value is readable the same cycle (head bypass when empty), or a registered equivalent that meets N+1.
  - Sustained input at one pixel per 4 cycles: level stays <= 1.
  - On vblank_rise in RUN: if pixel count != FRAME_PIX, frame_err pulses the next cycle. The count clears. A push in that same cycle counts toward the new frame.
  - Pointers wrap modulo DEPTH. level = push count minus pop count, with full = DEPTH.
- out_col holds its last popped value in every state, including FLUSH.
- tft_initialized falling mid-frame: enter FLUSH next cycle and discard buffered pixels. Any out_write already registered that cycle still completes.

Test Plan:
- Reset, tft_initialized=0, in_write pulses with in_col=3 -> out_write never high, level=0, overflow=0.
- Init high, then 10 in_write pulses before any vblank -> no out_write. vblank rise, then push col=2 at cycle N -> out_write at N+1 with out_col=2.
- In RUN, burst of 20 consecutive in_write (cols 0,1,2,3 repeating) -> first 16 + pops accepted. out_write pulses exactly 4 cycles apart. overflow set on the first dropped push; output sequence in order with no duplicates.
- Full FIFO with drain timer expiring in the same cycle as in_write -> push accepted, level stays 16, overflow unchanged.
- Frame of 23040 pixels at 1 per 4 cycles, then vblank rise -> no frame_err, level <= 1 throughout. Next frame of 23039 pixels, then vblank rise -> frame_err pulse for 1 cycle.
- tft_initialized dropped with level=5 -> level=0 next cycle, no further out_write. Reassert -> SYNC; pixels ignored until the next vblank rise.
